// File: rtl/column_height_buffer_pkg.sv
// Shared constants and types for the per-column wall store and its producers/consumers.
package column_height_buffer_pkg;

    localparam int unsigned NUM_COLS = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned H_W      = 9;
    localparam int unsigned TAG_W    = 3;
    localparam int unsigned X_W      = 10;
    localparam int unsigned Y_W      = 9;
    localparam int unsigned ADDR_W   = X_W + 1;
    localparam int unsigned SPAN_W   = H_W + 1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic [H_W-1:0]   height;
        logic [TAG_W-1:0] tag;
    } col_word_t;

    localparam int unsigned WORD_W = $bits(col_word_t);

    // Heights taller than the screen are clamped to a full-height wall.
    function automatic logic [H_W-1:0] sat_height(input logic [H_W-1:0] h);
        return (h > H_W'(SCREEN_H)) ? H_W'(SCREEN_H) : h;
    endfunction

endpackage

// File: rtl/column_height_buffer_col_ram.sv
// Simple dual-port column RAM: one write port, one registered read port; address MSB selects the bank.
module col_ram
    import column_height_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [2][NUM_COLS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[X_W]][wr_addr[X_W-1:0]] <= wr_data;
        end
    end

    // Read data holds its last value when no read is issued.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr[X_W]][rd_addr[X_W-1:0]];
        end
    end

endmodule

// File: rtl/column_height_buffer.sv
// Double-buffered per-column wall store: raycaster fills one bank while VGA reads the other;
// banks swap at frame start only when a complete frame has been written.
module column_height_buffer
    import column_height_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [H_W-1:0]   wr_height,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             frame_start,
    output logic             cast_start,
    output logic             swap_done,
    output logic             frame_dropped,
    input  logic             rd_en,
    input  logic [X_W-1:0]   rd_x,
    input  logic [Y_W-1:0]   rd_y,
    output logic             pix_valid,
    output logic             pix_wall,
    output logic [TAG_W-1:0] pix_tag
);

    wr_state_t      state, state_n;
    logic [X_W-1:0] wr_idx, wr_idx_n;
    logic           wr_sel, wr_sel_n;
    logic           disp_valid, disp_valid_n;
    logic           started;
    logic           wr_ready_n;
    logic           accept, last_col, swap, drop;

    col_word_t      wr_word;
    col_word_t      rd_word;
    logic [WORD_W-1:0] rd_data;
    logic           rd_hit;

    logic           s1_valid, s1_hit, s1_disp_valid;
    logic [Y_W-1:0] s1_y;

    logic [SPAN_W-1:0] span_top, span_end, y_ext;
    logic              wall;

    assign accept   = wr_valid & wr_ready;
    assign last_col = accept & (wr_idx == X_W'(NUM_COLS - 1));

    // Write FSM next state; a frame_start coinciding with the final column still counts as complete.
    always_comb begin
        state_n      = state;
        wr_idx_n     = wr_idx;
        wr_sel_n     = wr_sel;
        disp_valid_n = disp_valid;
        swap         = 1'b0;
        drop         = 1'b0;
        wr_ready_n   = 1'b0;

        case (state)
            ST_FILL: begin
                if (accept && !last_col) begin
                    wr_idx_n = wr_idx + X_W'(1);
                end
                if (frame_start) begin
                    if (last_col) begin
                        swap = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (last_col) begin
                    state_n = ST_FULL;
                end
            end
            ST_FULL: begin
                if (frame_start) begin
                    swap = 1'b1;
                end
            end
            default: state_n = ST_FILL;
        endcase

        if (swap) begin
            wr_sel_n     = ~wr_sel;
            disp_valid_n = 1'b1;
            wr_idx_n     = '0;
            state_n      = ST_FILL;
        end

        // Hold ready low for one cycle after a swap so the raycaster sees cast_start first.
        wr_ready_n = (state_n == ST_FILL) && !swap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_FILL;
            wr_idx        <= '0;
            wr_sel        <= 1'b0;
            disp_valid    <= 1'b0;
            wr_ready      <= 1'b0;
            started       <= 1'b0;
            cast_start    <= 1'b0;
            swap_done     <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            state         <= state_n;
            wr_idx        <= wr_idx_n;
            wr_sel        <= wr_sel_n;
            disp_valid    <= disp_valid_n;
            wr_ready      <= wr_ready_n;
            started       <= 1'b1;
            cast_start    <= ~started | swap;
            swap_done     <= swap;
            frame_dropped <= drop;
        end
    end

    assign wr_word.height = sat_height(wr_height);
    assign wr_word.tag    = wr_tag;

    // Out-of-range columns never touch the RAM and always read as no wall.
    assign rd_hit = rd_en && (rd_x < X_W'(NUM_COLS));

    col_ram u_col_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr ({wr_sel, wr_idx}),
        .wr_data (wr_word),
        .rd_en   (rd_hit),
        .rd_addr ({~wr_sel, rd_x}),
        .rd_data (rd_data)
    );

    assign rd_word = col_word_t'(rd_data);

    // Stage 1: RAM access in flight; capture the request alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_hit        <= 1'b0;
            s1_disp_valid <= 1'b0;
            s1_y          <= '0;
        end else begin
            s1_valid      <= rd_en;
            s1_hit        <= rd_hit;
            s1_disp_valid <= disp_valid;
            s1_y          <= rd_y;
        end
    end

    // Stage 2: wall span is vertically centred on the screen.
    always_comb begin
        span_top = SPAN_W'((SPAN_W'(SCREEN_H) - SPAN_W'(rd_word.height)) >> 1);
        span_end = span_top + SPAN_W'(rd_word.height);
        y_ext    = SPAN_W'(s1_y);
        wall     = s1_disp_valid && s1_hit && (y_ext >= span_top) && (y_ext < span_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_wall  <= 1'b0;
            pix_tag   <= '0;
        end else begin
            pix_valid <= s1_valid;
            pix_wall  <= wall;
            pix_tag   <= wall ? rd_word.tag : '0;
        end
    end

endmodule

// File: tb/tb_column_height_buffer.sv
// Scoreboard bench for column_height_buffer: a behavioural model predicts handshake, swap and pixel results.
module tb_column_height_buffer;
    import column_height_buffer_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [H_W-1:0]   wr_height = '0;
    logic [TAG_W-1:0] wr_tag = '0;
    logic             frame_start = 1'b0;
    logic             cast_start, swap_done, frame_dropped;
    logic             rd_en = 1'b0;
    logic [X_W-1:0]   rd_x = '0;
    logic [Y_W-1:0]   rd_y = '0;
    logic             pix_valid, pix_wall;
    logic [TAG_W-1:0] pix_tag;

    column_height_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_height     (wr_height),
        .wr_tag        (wr_tag),
        .frame_start   (frame_start),
        .cast_start    (cast_start),
        .swap_done     (swap_done),
        .frame_dropped (frame_dropped),
        .rd_en         (rd_en),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .pix_valid     (pix_valid),
        .pix_wall      (pix_wall),
        .pix_tag       (pix_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit w;
        int t;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    bit   m_full, m_sel, m_dv, m_ready, m_first;
    int   m_idx;
    int   mh[2][640];
    int   mt[2][640];
    int   mode = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Column data the "raycaster" offers for the column it is currently on.
    task automatic set_wdata();
        case (mode)
            1: begin
                if (m_idx == 3) begin
                    wr_height = 9'd511; wr_tag = 3'd2;
                end else if (m_idx == 4) begin
                    wr_height = 9'd0;   wr_tag = 3'd1;
                end else begin
                    wr_height = 9'd100; wr_tag = 3'd5;
                end
            end
            2: begin
                wr_height = 9'd200; wr_tag = 3'd3;
            end
            3: begin
                if (m_idx == 5) begin
                    wr_height = 9'd400; wr_tag = 3'd6;
                end else begin
                    wr_height = 9'($urandom_range(0, 511)); wr_tag = 3'($urandom_range(0, 7));
                end
            end
            default: begin
                wr_height = 9'($urandom_range(0, 511)); wr_tag = 3'($urandom_range(0, 7));
            end
        endcase
    endtask

    task automatic rand_read();
        rd_en = 1'b1;
        rd_x  = 10'($urandom_range(0, 679));
        rd_y  = 9'($urandom_range(0, 479));
    endtask

    // One clock: predict, advance, then compare registered outputs.
    task automatic step();
        exp_t e;
        bit   bank, acc, last, swp, drp, n_full, n_sel, n_dv, e_cast;
        int   n_idx, h, top;

        bank = ~m_sel;
        e.v = rd_en; e.w = 1'b0; e.t = 0;
        if (rd_en && m_dv && rd_x < 10'(NUM_COLS)) begin
            h   = mh[bank][rd_x];
            top = (480 - h) / 2;
            if (int'(rd_y) >= top && int'(rd_y) < top + h) begin
                e.w = 1'b1;
                e.t = mt[bank][rd_x];
            end
        end
        q.push_back(e);

        acc = wr_valid && m_ready;
        last = 0; swp = 0; drp = 0;
        n_full = m_full; n_idx = m_idx; n_sel = m_sel; n_dv = m_dv;
        if (m_full) begin
            if (frame_start) swp = 1;
        end else begin
            if (acc) begin
                mh[m_sel][m_idx] = (int'(wr_height) > 480) ? 480 : int'(wr_height);
                mt[m_sel][m_idx] = int'(wr_tag);
                if (m_idx == 639) last = 1;
                else n_idx = m_idx + 1;
            end
            if (frame_start) begin
                if (last) swp = 1;
                else drp = 1;
            end else if (last) begin
                n_full = 1;
            end
        end
        if (swp) begin
            n_sel = ~m_sel; n_dv = 1; n_idx = 0; n_full = 0;
        end
        e_cast = m_first || swp;

        @(posedge clk);
        #1;
        m_full = n_full; m_idx = n_idx; m_sel = n_sel; m_dv = n_dv; m_first = 0;
        m_ready = !n_full && !swp;

        check_eq("wr_ready", wr_ready, m_ready);
        check_eq("cast_start", cast_start, e_cast);
        check_eq("swap_done", swap_done, swp);
        check_eq("frame_dropped", frame_dropped, drp);
        if (q.size() >= 2) begin
            e = q.pop_front();
            check_eq("pix_valid", pix_valid, e.v);
            check_eq("pix_wall", pix_wall, e.w);
            check_eq("pix_tag", pix_tag, e.t);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_valid = 1'b0; frame_start = 1'b0; rd_en = 1'b0;
        #1;
        check_eq("rst_wr_ready", wr_ready, 0);
        check_eq("rst_cast_start", cast_start, 0);
        check_eq("rst_swap_done", swap_done, 0);
        check_eq("rst_frame_dropped", frame_dropped, 0);
        check_eq("rst_pix_valid", pix_valid, 0);
        check_eq("rst_pix_wall", pix_wall, 0);
        check_eq("rst_pix_tag", pix_tag, 0);
        repeat (2) @(posedge clk);
        #1;
        m_full = 0; m_idx = 0; m_sel = 0; m_dv = 0; m_ready = 0; m_first = 1;
        q.delete();
        rst_n = 1'b1;
    endtask

    task automatic idle(input int k);
        wr_valid = 1'b0; frame_start = 1'b0;
        repeat (k) begin
            rand_read();
            step();
        end
    endtask

    task automatic pulse_fs();
        wr_valid = 1'b0; frame_start = 1'b1;
        rand_read();
        step();
        frame_start = 1'b0;
    endtask

    task automatic read_at(input int x, input int y);
        wr_valid = 1'b0; frame_start = 1'b0;
        rd_en = 1'b1; rd_x = 10'(x); rd_y = 9'(y);
        step();
    endtask

    // Push n columns with random valid gaps; bounded so a stuck ready cannot hang the run.
    task automatic fill(input int n, input int gap);
        int got    = 0;
        int budget = n * 10 + 50;
        frame_start = 1'b0;
        while (got < n && budget > 0) begin
            wr_valid = ($urandom_range(0, 99) >= gap);
            set_wdata();
            rand_read();
            if (wr_valid && m_ready) got++;
            step();
            budget--;
        end
        wr_valid = 1'b0;
        check_eq("fill_count", got, n);
    endtask

    initial begin
        #2;
        do_reset();
        idle(8);

        // Frame A: uniform height 100 plus saturated and zero-height columns.
        mode = 1;
        fill(640, 0);
        idle(3);
        pulse_fs();
        read_at(10, 189);
        read_at(10, 190);
        read_at(10, 289);
        read_at(10, 290);
        read_at(700, 200);
        for (int y = 0; y < 480; y++) read_at(3, y);
        for (int y = 0; y < 480; y++) read_at(4, y);

        // Frame B arrives late: first frame_start is dropped, the second swaps.
        mode = 2;
        fill(300, 30);
        pulse_fs();
        read_at(10, 190);
        read_at(10, 150);
        fill(340, 30);
        idle(2);
        pulse_fs();
        read_at(10, 150);
        read_at(10, 139);

        // Frame C: last column accepted together with frame_start.
        mode = 3;
        fill(639, 20);
        wr_valid = 1'b1; set_wdata(); frame_start = 1'b1;
        rd_en = 1'b1; rd_x = 10'd5; rd_y = 9'd100;
        step();
        wr_valid = 1'b0; frame_start = 1'b0;
        read_at(5, 100);
        idle(3);

        // Random traffic: gaps on the writer, reads every cycle, sporadic frame_start.
        mode = 0;
        repeat (6000) begin
            wr_valid    = ($urandom_range(0, 99) < 60);
            set_wdata();
            frame_start = ($urandom_range(0, 299) == 0);
            rand_read();
            step();
        end
        wr_valid = 1'b0; frame_start = 1'b0;
        if (m_full) pulse_fs();
        idle(2);
        fill(50, 20);

        // Reset in the middle of a fill, then confirm nothing is displayed.
        do_reset();
        idle(10);
        read_at(10, 240);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
